// File: rtl/pmem_burst_responder.sv
// ---------------------------------------------------------------------------
// pmem_burst_responder
//   Target end of the pmem interface. Serves 256-bit cache-line reads and
//   writes as four 64-bit beats after a programmable access latency, backed
//   by an internal line-organised array (contents are not reset).
//
// Parameters
//   LINES_LOG2  log2 of the number of 256-bit lines in the array
//   LATENCY     cycles spent waiting before the first beat (1..255)
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   pmem_read     read-line request, held until its burst completes
//   pmem_write    write-line request, held until its burst completes
//   pmem_address  line address; [4:0] ignored, upper bits wrap
//   pmem_wdata    write beat k, held until the k-th pmem_resp
//   beat_stall    (PMEM_BEAT_STALL_EN only) hold off the next beat
//   pmem_resp     registered beat strobe
//   pmem_rdata    registered read beat, valid with pmem_resp on reads
//
// Build option
//   PMEM_BEAT_STALL_EN  adds beat_stall; without it beats are back-to-back.
// ---------------------------------------------------------------------------
module pmem_burst_responder #(
    parameter int unsigned LINES_LOG2 = 10,
    parameter int unsigned LATENCY    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
`ifdef PMEM_BEAT_STALL_EN
    input  logic        beat_stall,
`endif
    output logic        pmem_resp,
    output logic [63:0] pmem_rdata
);

    localparam int unsigned LINE_W  = LINES_LOG2;
    localparam int unsigned NLINES  = 1 << LINES_LOG2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BEAT_W  = 2;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned LINE_BW = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic                op_rd_q, op_rd_d;
    logic                resp_q,  resp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [LINE_BW-1:0]  mem_q [NLINES];

    logic                stall_c;
    logic                commit_c;
    logic [BEAT_W-1:0]   beat_nxt_c;
    logic [DATA_W-1:0]   rd_word_c;

    // Address bits outside the line index are deliberately ignored.
    logic                unused_addr;
    assign unused_addr = ^{pmem_address[31:LINE_W+5], pmem_address[4:0]};

`ifdef PMEM_BEAT_STALL_EN
    assign stall_c = beat_stall;
`else
    assign stall_c = 1'b0;
`endif

    // Word that will be presented next: lookahead of the beat index.
    assign rd_word_c = mem_q[line_q][{beat_nxt_c, 6'd0} +: DATA_W];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            op_rd_q <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            op_rd_q <= op_rd_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        line_d     = line_q;
        op_rd_d    = op_rd_q;
        resp_d     = 1'b0;
        rdata_d    = rdata_q;
        commit_c   = 1'b0;
        beat_nxt_c = beat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    line_d  = pmem_address[LINE_W+4:5];
                    op_rd_d = pmem_read;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    beat_d  = '0;
                    state_d = ST_BURST;
                end else begin
                    cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                end
            end
            ST_BURST: begin
                // resp_q high means beat_q is on the bus this cycle and is
                // retired at this edge; otherwise we are at the start of the
                // burst or coming out of a stall.
                if (resp_q) begin
                    commit_c = !op_rd_q;
                    if (beat_q == BEAT_W'(3)) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_nxt_c = BEAT_W'(beat_q + BEAT_W'(1));
                    end
                end
                if (state_d == ST_BURST) begin
                    beat_d = beat_nxt_c;
                    if (!stall_c) begin
                        resp_d  = 1'b1;
                        rdata_d = rd_word_c;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Backing store: one 64-bit slice committed per retired write beat.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem_q[line_q][{beat_q, 6'd0} +: DATA_W] <= pmem_wdata;
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
`timescale 1ns/1ps
module tb_pmem_burst_responder;

    localparam int unsigned LINES_LOG2 = 10;
    localparam int unsigned LATENCY    = 8;

    logic        clk;
    logic        rst;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
`ifdef PMEM_BEAT_STALL_EN
    logic        beat_stall;
`endif
    logic        pmem_resp;
    logic [63:0] pmem_rdata;

    int checks = 0;
    int errors = 0;

    logic [255:0] model [1 << LINES_LOG2];
    logic [63:0]  wbeats [4];
    logic [63:0]  rd_q [$];
    int           resp_cyc [$];

    pmem_burst_responder #(
        .LINES_LOG2 (LINES_LOG2),
        .LATENCY    (LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
`ifdef PMEM_BEAT_STALL_EN
        .beat_stall   (beat_stall),
`endif
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 5) & ((32'd1 << LINES_LOG2) - 32'd1));
    endfunction

    task automatic model_write(input logic [31:0] addr, input int nbeats);
        int ln;
        ln = line_of(addr);
        for (int k = 0; k < nbeats; k++) model[ln][64*k +: 64] = wbeats[k];
    endtask

    task automatic push_reads(input logic [31:0] addr);
        int ln;
        ln = line_of(addr);
        for (int k = 0; k < 4; k++) rd_q.push_back(model[ln][64*k +: 64]);
    endtask

    // Drives one request (held across `bursts` bursts) from a negedge.
    // Cycle n is the interval after request-sampling edge n.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input int bursts,
                           input int stall_after);
        int idx;
        int cyc;
        int nresp;
        int stall_left;
        logic [63:0] exp;
        logic [63:0] last;
        idx = 0; cyc = 0; nresp = 0; stall_left = 0; last = '0;
        resp_cyc.delete();
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wbeats[0];
        while (nresp < 4*bursts && cyc < 200) begin
            @(negedge clk);
            pmem_wdata = wbeats[idx % 4];
            if (pmem_resp) begin
                resp_cyc.push_back(cyc);
                if (rd) begin
                    exp = (rd_q.size() > 0) ? rd_q.pop_front() : 64'hDEAD_BEEF;
                    check({tag, "_rdata"}, pmem_rdata, exp);
                    last = exp;
                end
                idx++;
                nresp++;
                if (nresp == stall_after) stall_left = 2;
                if (nresp == 4*bursts) begin
                    pmem_read  = 1'b0;
                    pmem_write = 1'b0;
                end
            end
`ifdef PMEM_BEAT_STALL_EN
            beat_stall = (stall_left > 0);
`endif
            if (stall_left > 0) stall_left--;
            cyc++;
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        check({tag, "_nbeats"}, 64'(nresp), 64'(4*bursts));
        @(negedge clk);
        check({tag, "_resp_fall"}, 64'(pmem_resp), 64'd0);
        if (rd) check({tag, "_rdata_hold"}, pmem_rdata, last);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int nresp;
        int idx;
        clk = 1'b0;
        rst = 1'b1;
        pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_address = '0; pmem_wdata = '0;
`ifdef PMEM_BEAT_STALL_EN
        beat_stall = 1'b0;
`endif
        for (int i = 0; i < (1 << LINES_LOG2); i++) model[i] = '0;

        #1 rst = 1'b0;
        #2;
        check("reset_resp", 64'(pmem_resp), 64'd0);
        check("reset_rdata", pmem_rdata, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Preload line 3, then read it and check beat timing.
        wbeats = '{64'hA, 64'hB, 64'hC, 64'hD};
        model_write(32'h60, 4);
        run_txn("preload", 1'b0, 1'b1, 32'h60, 1, 0);
        push_reads(32'h60);
        run_txn("rd_lat", 1'b1, 1'b0, 32'h60, 1, 0);
        check("rd_lat_first", 64'(resp_cyc[0]), 64'(LATENCY + 1));
        check("rd_lat_last",  64'(resp_cyc[3]), 64'(LATENCY + 4));

        // Write then read back.
        wbeats = '{64'h11, 64'h22, 64'h33, 64'h44};
        model_write(32'h1A0, 4);
        run_txn("wr1a0", 1'b0, 1'b1, 32'h1A0, 1, 0);
        push_reads(32'h1A0);
        run_txn("rd1a0", 1'b1, 1'b0, 32'h1A0, 1, 0);

        // Priority and address wrap on line 1.
        wbeats = '{64'h0101_0000_0000_0001, 64'h0202, 64'h0303, 64'h0404};
        model_write(32'h20, 4);
        run_txn("wr_l1", 1'b0, 1'b1, 32'h20, 1, 0);
        wbeats = '{64'hBAD0, 64'hBAD1, 64'hBAD2, 64'hBAD3};
        push_reads((32'd1 << (LINES_LOG2 + 5)) | 32'h20);
        run_txn("prio_wrap", 1'b1, 1'b1, (32'd1 << (LINES_LOG2 + 5)) | 32'h20, 1, 0);
        push_reads(32'h3F);
        run_txn("low_bits", 1'b1, 1'b0, 32'h3F, 1, 0);
        push_reads(32'h20);
        run_txn("no_change", 1'b1, 1'b0, 32'h20, 1, 0);

        // Back-to-back: last beat at cycle L+4, DONE at edge L+5, IDLE at
        // L+6, resampled at edge L+7, so next first beat at 2L+8.
        push_reads(32'h60);
        push_reads(32'h60);
        run_txn("b2b", 1'b1, 1'b0, 32'h60, 2, 0);
        check("b2b_gap", 64'(resp_cyc[4] - resp_cyc[3]), 64'(LATENCY + 4));

        // Reset in the middle of a write burst, after beat 1 commits.
        wbeats = '{64'h55, 64'h66, 64'h77, 64'h88};
        pmem_write = 1'b1; pmem_address = 32'h1A0; pmem_wdata = wbeats[0];
        cyc = 0; nresp = 0; idx = 0;
        while (nresp < 2 && cyc < 200) begin
            @(negedge clk);
            pmem_wdata = wbeats[idx];
            if (pmem_resp) begin idx++; nresp++; end
            cyc++;
        end
        check("rstmid_reached", 64'(nresp), 64'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rstmid_resp", 64'(pmem_resp), 64'd0);
        check("rstmid_rdata", pmem_rdata, 64'd0);
        pmem_write = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_write(32'h1A0, 2);
        push_reads(32'h1A0);
        run_txn("rstmid_rd", 1'b1, 1'b0, 32'h1A0, 1, 0);
        check("rstmid_idle_lat", 64'(resp_cyc[0]), 64'(LATENCY + 1));

`ifdef PMEM_BEAT_STALL_EN
        // Two stall cycles after beat 1: beats at L+1, L+2, L+5, L+6.
        wbeats = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
        model_write(32'hA0, 4);
        run_txn("stall_wr", 1'b0, 1'b1, 32'hA0, 1, 2);
        check("stall_b2", 64'(resp_cyc[2]), 64'(LATENCY + 5));
        check("stall_b3", 64'(resp_cyc[3]), 64'(LATENCY + 6));
        push_reads(32'hA0);
        run_txn("stall_rd", 1'b1, 1'b0, 32'hA0, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
